// File: rtl/prog_load_sequencer.sv
// Program load/run sequencer for the 4-bit CPU system.
// Holds the CPU in reset, streams a program into instruction memory, then
// releases the CPU for a fixed cycle budget and re-asserts its reset.
//
// Ports:
//   clk, reset          single clock; synchronous active-high reset
//   start, abort        launch a sequence (IDLE only) / cancel from any state
//   prog_len            words to load (clamped to memory depth; 0 = no load)
//   run_cycles          CPU run budget (0 = run until abort)
//   instr_valid/ready   valid/ready handshake from the instruction source
//   instr_data          instruction word
//   prog_enable         address mux select (1 = program address)
//   prog_we/addr/data   instruction memory write port
//   cpu_reset           CPU reset, active-high
//   busy, done          not-IDLE flag / one-cycle completion pulse
module prog_load_sequencer #(
    parameter int ADDR_WIDTH    = 4,
    parameter int INSTR_WIDTH   = 8,
    parameter int RUN_CNT_WIDTH = 16,
    parameter int RST_HOLD      = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDR_WIDTH:0]      prog_len,
    input  logic [RUN_CNT_WIDTH-1:0] run_cycles,
    input  logic                     instr_valid,
    input  logic [INSTR_WIDTH-1:0]   instr_data,
    output logic                     instr_ready,
    output logic                     prog_enable,
    output logic                     prog_we,
    output logic [ADDR_WIDTH-1:0]    prog_addr,
    output logic [INSTR_WIDTH-1:0]   prog_data,
    output logic                     cpu_reset,
    output logic                     busy,
    output logic                     done
);

    localparam int LEN_W  = ADDR_WIDTH + 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [LEN_W-1:0]         DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [HOLD_W-1:0]        HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [RUN_CNT_WIDTH-1:0] RUN_ONE   = RUN_CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [LEN_W-1:0]         len_q, len_d;
    logic [LEN_W-1:0]         idx_q, idx_d;
    logic [RUN_CNT_WIDTH-1:0] run_len_q, run_len_d;
    logic [RUN_CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
    logic [HOLD_W-1:0]        settle_cnt_q, settle_cnt_d;

    logic                     prog_enable_q, prog_enable_d;
    logic                     prog_we_q, prog_we_d;
    logic [ADDR_WIDTH-1:0]    prog_addr_q, prog_addr_d;
    logic [INSTR_WIDTH-1:0]   prog_data_q, prog_data_d;
    logic                     cpu_reset_q, cpu_reset_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [LEN_W-1:0] start_len;
    logic [LEN_W-1:0] idx_inc;
    logic             run_last;

    // Requests longer than the memory are clamped so addresses never wrap.
    assign start_len = (prog_len > DEPTH) ? DEPTH : prog_len;
    assign idx_inc   = idx_q + LEN_W'(1);

    // A zero budget never matches, so the CPU runs until abort.
    assign run_last = (run_len_q != '0) && (run_cnt_q == run_len_q - RUN_ONE);

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        run_len_d     = run_len_q;
        run_cnt_d     = run_cnt_q;
        settle_cnt_d  = settle_cnt_q;
        prog_enable_d = prog_enable_q;
        prog_we_d     = 1'b0;
        prog_addr_d   = prog_addr_q;
        prog_data_d   = prog_data_q;
        cpu_reset_d   = cpu_reset_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cpu_reset_d = 1'b1;
                busy_d      = 1'b0;
                if (start && !abort) begin
                    len_d         = start_len;
                    run_len_d     = run_cycles;
                    idx_d         = '0;
                    run_cnt_d     = '0;
                    settle_cnt_d  = '0;
                    prog_enable_d = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = (start_len != '0) ? S_LOAD : S_SETTLE;
                end
            end

            S_LOAD: begin
                // instr_ready is high throughout LOAD.
                if (instr_valid) begin
                    prog_we_d   = 1'b1;
                    prog_addr_d = idx_q[ADDR_WIDTH-1:0];
                    prog_data_d = instr_data;
                    idx_d       = idx_inc;
                    if (idx_inc == len_q) begin
                        settle_cnt_d = '0;
                        state_d      = S_SETTLE;
                    end
                end
            end

            S_SETTLE: begin
                // First cycle still shows the final write; the port is
                // parked from the next edge on.
                prog_enable_d = 1'b0;
                prog_addr_d   = '0;
                prog_data_d   = '0;
                if (settle_cnt_q == HOLD_LAST) begin
                    cpu_reset_d = 1'b0;
                    run_cnt_d   = '0;
                    state_d     = S_RUN;
                end else begin
                    settle_cnt_d = settle_cnt_q + HOLD_W'(1);
                end
            end

            S_RUN: begin
                if (run_last) begin
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end else if (run_len_q != '0) begin
                    run_cnt_d = run_cnt_q + RUN_ONE;
                end
            end

            S_DONE: begin
                cpu_reset_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end

            default: begin
                cpu_reset_d   = 1'b1;
                busy_d        = 1'b0;
                prog_enable_d = 1'b0;
                state_d       = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a beat in the same cycle.
        if (abort && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            cpu_reset_d   = 1'b1;
            prog_enable_d = 1'b0;
            prog_we_d     = 1'b0;
            prog_addr_d   = '0;
            prog_data_d   = '0;
            busy_d        = 1'b0;
            done_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            idx_q         <= '0;
            run_len_q     <= '0;
            run_cnt_q     <= '0;
            settle_cnt_q  <= '0;
            prog_enable_q <= 1'b0;
            prog_we_q     <= 1'b0;
            prog_addr_q   <= '0;
            prog_data_q   <= '0;
            cpu_reset_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            run_len_q     <= run_len_d;
            run_cnt_q     <= run_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            prog_enable_q <= prog_enable_d;
            prog_we_q     <= prog_we_d;
            prog_addr_q   <= prog_addr_d;
            prog_data_q   <= prog_data_d;
            cpu_reset_q   <= cpu_reset_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign instr_ready = (state_q == S_LOAD);
    assign prog_enable = prog_enable_q;
    assign prog_we     = prog_we_q;
    assign prog_addr   = prog_addr_q;
    assign prog_data   = prog_data_q;
    assign cpu_reset   = cpu_reset_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_prog_load_sequencer.sv
// Testbench for prog_load_sequencer.
// Randomised scenarios checked against a cycle-count model of the sequence.
module tb_prog_load_sequencer;

    localparam int AW   = 4;
    localparam int IW   = 8;
    localparam int RW   = 16;
    localparam int RH   = 2;
    localparam int LW   = AW + 1;
    localparam int MAXC = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [LW-1:0] prog_len;
    logic [RW-1:0] run_cycles;
    logic          instr_valid;
    logic [IW-1:0] instr_data;
    logic          instr_ready;
    logic          prog_enable;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic          cpu_reset;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    logic [IW-1:0] words [32];
    bit            pat   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Per-cycle trace, index n = cycle after the edge that sampled start.
    logic          t_we    [MAXC];
    logic          t_pe    [MAXC];
    logic          t_rst   [MAXC];
    logic          t_done  [MAXC];
    logic          t_busy  [MAXC];
    bit            t_valid [MAXC];
    logic [AW-1:0] t_addr  [MAXC];
    logic [IW-1:0] t_data  [MAXC];
    int            n_end;

    // Model expectations
    bit exp_we [MAXC];
    int exp_settle;
    int exp_first_low;
    int exp_done_cyc;
    int exp_end;

    always #5 clk = ~clk;

    prog_load_sequencer #(
        .ADDR_WIDTH   (AW),
        .INSTR_WIDTH  (IW),
        .RUN_CNT_WIDTH(RW),
        .RST_HOLD     (RH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .prog_len   (prog_len),
        .run_cycles (run_cycles),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .instr_ready(instr_ready),
        .prog_enable(prog_enable),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic rand_words();
        for (int i = 0; i < 32; i++) words[i] = IW'($urandom);
    endtask

    // Reference model: the load accepts one word per valid cycle starting in
    // the cycle after start, until len words (clamped to 16) are in; the CPU
    // is released RST_HOLD cycles after the last write (or after start when
    // nothing is loaded), runs runc cycles, then done pulses for one cycle.
    task automatic model(input int len, input int runc, input int abort_at);
        int l, cnt, last;
        l    = (len > 16) ? 16 : len;
        cnt  = 0;
        last = 0;
        for (int n = 0; n < MAXC; n++) exp_we[n] = 1'b0;
        for (int n = 0; n < MAXC - 1 && cnt < l; n++) begin
            if (t_valid[n] && (abort_at < 0 || n < abort_at)) begin
                exp_we[n+1] = 1'b1;
                cnt++;
                last = n + 1;
            end
        end
        exp_settle    = (l == 0) ? 0 : last;
        exp_first_low = exp_settle + RH;
        exp_done_cyc  = exp_first_low + runc;
        exp_end       = (abort_at >= 0) ? abort_at + 1 : exp_done_cyc + 1;
    endtask

    // Runs one sequence and checks the properties common to every run.
    // vmode: 0 valid always, 1 random valid, 2 fixed gap pattern.
    task automatic run_seq(input int len, input int runc, input int vmode,
                           input int abort_at, input bit extra_start);
        int  n, k, w, lows, dones;
        bit  v;
        for (int i = 0; i < MAXC; i++) t_valid[i] = 1'b0;
        prog_len    = LW'(len);
        run_cycles  = RW'(runc);
        start       = 1'b1;
        abort       = 1'b0;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = 0;
        k     = 0;
        n_end = -1;
        while (n < MAXC - 1 && n_end < 0) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = 1'($urandom_range(0, 1));
                default: v = pat[n % 7];
            endcase
            instr_valid = v;
            instr_data  = words[k];
            abort       = (n == abort_at);
            start       = extra_start && (n == 3 || n == 20);
            t_valid[n]  = v;
            @(negedge clk);
            t_we[n]   = prog_we;
            t_pe[n]   = prog_enable;
            t_rst[n]  = cpu_reset;
            t_done[n] = done;
            t_busy[n] = busy;
            t_addr[n] = prog_addr;
            t_data[n] = prog_data;
            if (v && instr_ready && k < 31) k++;
            if (busy !== 1'b1) begin
                n_end = n;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        instr_valid = 1'b0;
        abort       = 1'b0;
        start       = 1'b0;

        model(len, runc, abort_at);

        checks++;
        if (n_end !== exp_end) begin
            failures++;
            $display("FAIL seq_end len=%0d runc=%0d got=%0d exp=%0d",
                     len, runc, n_end, exp_end);
        end
        if (n_end < 0) n_end = MAXC - 2;

        w = 0;
        for (int i = 0; i <= n_end; i++) begin
            checks++;
            if (t_we[i] !== exp_we[i]) begin
                failures++;
                $display("FAIL prog_we cyc=%0d len=%0d got=%b exp=%b",
                         i, len, t_we[i], exp_we[i]);
            end
            if (t_we[i] === 1'b1) begin
                checks++;
                if (t_addr[i] !== AW'(w) || t_data[i] !== words[w]
                    || t_pe[i] !== 1'b1) begin
                    failures++;
                    $display("FAIL write%0d got addr=%0d data=%h pe=%b exp addr=%0d data=%h pe=1",
                             w, t_addr[i], t_data[i], t_pe[i], w, words[w]);
                end
                w++;
            end
        end

        lows  = 0;
        dones = 0;
        for (int i = 0; i <= n_end; i++) begin
            if (t_rst[i] === 1'b0) lows++;
            if (t_done[i] === 1'b1) dones++;
        end
        checks++;
        if (abort_at < 0) begin
            if (lows !== runc || dones !== 1 || t_done[exp_done_cyc] !== 1'b1
                || t_rst[exp_first_low] !== 1'b0
                || t_rst[exp_first_low-1] !== 1'b1) begin
                failures++;
                $display("FAIL run_window lows=%0d dones=%0d exp lows=%0d dones=1 first_low=%0d",
                         lows, dones, runc, exp_first_low);
            end
        end else begin
            if (dones !== 0) begin
                failures++;
                $display("FAIL abort_done got=%0d exp=0", dones);
            end
        end

        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = '0;
        prog_len    = '0;
        run_cycles  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cpu_reset, prog_enable, prog_we, busy, done, instr_ready}
            !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=100000",
                     {cpu_reset, prog_enable, prog_we, busy, done, instr_ready});
        end
        checks++;
        if (prog_addr !== '0 || prog_data !== '0) begin
            failures++;
            $display("FAIL reset_port got addr=%0d data=%h exp 0/00",
                     prog_addr, prog_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        rand_words();
        words[0] = 8'hA1;
        words[1] = 8'hB2;
        words[2] = 8'hC3;
        run_seq(3, 10, 0, -1, 1'b0);
        checks++;
        if (t_we[1] !== 1'b1 || t_we[2] !== 1'b1 || t_we[3] !== 1'b1) begin
            failures++;
            $display("FAIL basic_consec got=%b%b%b exp=111",
                     t_we[1], t_we[2], t_we[3]);
        end
        checks++;
        if (t_pe[exp_settle] !== 1'b1 || t_pe[exp_settle+1] !== 1'b0
            || t_addr[exp_settle+1] !== '0 || t_data[exp_settle+1] !== '0) begin
            failures++;
            $display("FAIL basic_settle got pe=%b%b addr=%0d data=%h exp pe=10 addr=0 data=00",
                     t_pe[exp_settle], t_pe[exp_settle+1],
                     t_addr[exp_settle+1], t_data[exp_settle+1]);
        end
        checks++;
        if (t_busy[exp_done_cyc] !== 1'b1 || t_busy[exp_done_cyc+1] !== 1'b0
            || t_rst[exp_done_cyc] !== 1'b1) begin
            failures++;
            $display("FAIL basic_done got busy=%b%b rst=%b exp busy=10 rst=1",
                     t_busy[exp_done_cyc], t_busy[exp_done_cyc+1],
                     t_rst[exp_done_cyc]);
        end
    endtask

    task automatic test_gaps();
        int nw;
        rand_words();
        run_seq(4, 5, 2, -1, 1'b0);
        nw = 0;
        for (int i = 0; i <= n_end; i++) if (t_we[i] === 1'b1) nw++;
        checks++;
        if (nw !== 4) begin
            failures++;
            $display("FAIL gaps_count got=%0d exp=4", nw);
        end
    endtask

    task automatic test_full_depth();
        int nw;
        for (int r = 0; r < 2; r++) begin
            rand_words();
            run_seq((r == 0) ? 16 : 20, 3, 1, -1, 1'b0);
            nw = 0;
            for (int i = 0; i <= n_end; i++) if (t_we[i] === 1'b1) nw++;
            checks++;
            if (nw !== 16) begin
                failures++;
                $display("FAIL full_count r=%0d got=%0d exp=16", r, nw);
            end
        end
    endtask

    task automatic test_zero_abort();
        rand_words();
        run_seq(0, 0, 1, 50, 1'b0);
        checks++;
        if (t_rst[RH-1] !== 1'b1 || t_rst[RH] !== 1'b0 || t_rst[50] !== 1'b0) begin
            failures++;
            $display("FAIL zero_release got=%b%b%b exp=100",
                     t_rst[RH-1], t_rst[RH], t_rst[50]);
        end
        checks++;
        if (t_rst[51] !== 1'b1 || t_busy[51] !== 1'b0 || t_pe[51] !== 1'b0) begin
            failures++;
            $display("FAIL zero_abort got rst=%b busy=%b pe=%b exp 1/0/0",
                     t_rst[51], t_busy[51], t_pe[51]);
        end
    endtask

    task automatic test_abort_load();
        int nw;
        rand_words();
        run_seq(5, 4, 0, 2, 1'b0);
        nw = 0;
        for (int i = 0; i <= n_end; i++) if (t_we[i] === 1'b1) nw++;
        checks++;
        if (nw !== 2 || t_we[3] !== 1'b0 || t_pe[3] !== 1'b0
            || t_busy[3] !== 1'b0 || t_rst[3] !== 1'b1) begin
            failures++;
            $display("FAIL abort_load got writes=%0d we=%b pe=%b busy=%b rst=%b exp 2/0/0/0/1",
                     nw, t_we[3], t_pe[3], t_busy[3], t_rst[3]);
        end
    endtask

    task automatic test_back_to_back();
        int len, runc;
        for (int r = 0; r < 6; r++) begin
            rand_words();
            len  = $urandom_range(0, 20);
            runc = $urandom_range(1, 30);
            run_seq(len, runc, (r < 3) ? 1 : 0, -1, 1'b1);
        end
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1;
        abort = 1'b1;
        prog_len = LW'(3);
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || prog_enable !== 1'b0 || instr_ready !== 1'b0
            || cpu_reset !== 1'b1) begin
            failures++;
            $display("FAIL start_abort got busy=%b pe=%b rdy=%b rst=%b exp 0/0/0/1",
                     busy, prog_enable, instr_ready, cpu_reset);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        rand_words();
        prog_len    = LW'(6);
        run_cycles  = RW'(5);
        start       = 1'b1;
        instr_valid = 1'b1;
        instr_data  = words[0];
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (prog_we !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre got we=%b busy=%b exp 1/1", prog_we, busy);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_reset, prog_enable, prog_we, busy, done, instr_ready} !== 6'b100000
            || prog_addr !== '0 || prog_data !== '0) begin
            failures++;
            $display("FAIL reset_mid got=%b addr=%0d data=%h exp=100000 0 00",
                     {cpu_reset, prog_enable, prog_we, busy, done, instr_ready},
                     prog_addr, prog_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_full_depth();
        test_zero_abort();
        test_abort_load();
        test_back_to_back();
        test_start_abort_idle();
        test_reset_mid();
        test_basic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
